// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    function automatic int cnt_width(input int flen);
        return $clog2(flen + 1);
    endfunction

    // Even parity over a word zero-extended to 64 bits; the padding does not change the XOR.
    function automatic logic parity_of(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: clear on word load, step once per shifted bit, flag the final bit.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int FLEN = 8,
    parameter int CW   = cnt_width(FLEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          last
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == CW'(FLEN - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with frame_start marker and gap-free back-to-back frames.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int CW = cnt_width(FLEN);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             cnt_last;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic             parity_bit;
    logic [63:0]      data_ext;

    assign data_ext = 64'(load_data);
`endif

    piso_bit_counter #(
        .FLEN (FLEN),
        .CW   (CW)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (cnt),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The last-bit cycle doubles as a load slot so a new frame can follow without a gap.
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE:    load_ready = 1'b1;
            SHIFT:   load_ready = cnt_last;
            default: load_ready = 1'b0;
        endcase
        accept = load_valid && load_ready;
        if (state == SHIFT) begin
            if (cnt_last) begin
                cnt_clear  = 1'b1;
                state_next = IDLE;
            end else begin
                cnt_inc = 1'b1;
            end
        end
        if (accept) begin
            cnt_clear  = 1'b1;
            cnt_inc    = 1'b0;
            state_next = SHIFT;
        end
    end

    // The first bit leaves straight from load_data; shreg holds the remaining bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg       <= '0;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else if (accept) begin
            ser_valid   <= 1'b1;
            frame_start <= 1'b1;
            if (MSB_FIRST) begin
                ser_out <= load_data[WIDTH-1];
                shreg   <= load_data << 1;
            end else begin
                ser_out <= load_data[0];
                shreg   <= load_data >> 1;
            end
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_bit  <= parity_of(data_ext);
`endif
        end else if (cnt_inc) begin
            ser_valid   <= 1'b1;
            frame_start <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            if (cnt == CW'(WIDTH - 1)) begin
                ser_out <= parity_bit;
            end else
`endif
            if (MSB_FIRST) begin
                ser_out <= shreg[WIDTH-1];
                shreg   <= shreg << 1;
            end else begin
                ser_out <= shreg[0];
                shreg   <= shreg >> 1;
            end
        end else begin
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
        end
    end

    assign busy = ser_valid;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: MSB-first and LSB-first instances share stimulus and are checked every cycle.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic       clk;
    logic       reset;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready_m, ser_out_m, ser_valid_m, frame_start_m, busy_m;
    logic       load_ready_l, ser_out_l, ser_valid_l, frame_start_l, busy_l;
    int         checks;
    int         errors;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready_m),
        .ser_out     (ser_out_m),
        .ser_valid   (ser_valid_m),
        .frame_start (frame_start_m),
        .busy        (busy_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready_l),
        .ser_out     (ser_out_l),
        .ser_valid   (ser_valid_l),
        .frame_start (frame_start_l),
        .busy        (busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%b expected=%b", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        load_valid = valid;
        load_data  = data;
    endtask

    function automatic logic expBit(input logic [7:0] w, input int i, input bit msb);
        if (i >= 8) return ^w;
        return msb ? w[7-i] : w[i];
    endfunction

    // idx < 0 means no frame in progress.
    task automatic checkCycle(input string tag, input logic [7:0] w, input int idx);
        logic exp_valid;
        logic exp_first;
        logic exp_ready;
        exp_valid = (idx >= 0);
        exp_first = (idx == 0);
        exp_ready = (idx < 0) || (idx == FLEN - 1);
        checkOutput({tag, " msb ser_out"},     ser_out_m,     exp_valid ? expBit(w, idx, 1'b1) : 1'b0);
        checkOutput({tag, " lsb ser_out"},     ser_out_l,     exp_valid ? expBit(w, idx, 1'b0) : 1'b0);
        checkOutput({tag, " msb ser_valid"},   ser_valid_m,   exp_valid);
        checkOutput({tag, " lsb ser_valid"},   ser_valid_l,   exp_valid);
        checkOutput({tag, " msb busy"},        busy_m,        exp_valid);
        checkOutput({tag, " msb frame_start"}, frame_start_m, exp_first);
        checkOutput({tag, " lsb frame_start"}, frame_start_l, exp_first);
        checkOutput({tag, " msb load_ready"},  load_ready_m,  exp_ready);
        checkOutput({tag, " lsb load_ready"},  load_ready_l,  exp_ready);
    endtask

    // Assumes the word was accepted at the previous edge; optionally raises load_valid mid-frame.
    task automatic runFrame(input string tag, input logic [7:0] w, input int hold_at, input logic [7:0] hold_word);
        for (int i = 0; i < FLEN; i++) begin
            @(negedge clk);
            checkCycle($sformatf("%s bit%0d", tag, i), w, i);
            if (i == 0) applyStimulus(1'b0, 8'h00);
            if (i == hold_at) applyStimulus(1'b1, hold_word);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        applyStimulus(1'b1, 8'hFF);
        @(negedge clk);
        checkCycle("reset0", 8'h00, -1);
        @(negedge clk);
        checkCycle("reset1", 8'h00, -1);
        applyStimulus(1'b0, 8'h00);
        reset = 1'b0;
        @(negedge clk);
        checkCycle("idle", 8'h00, -1);

        applyStimulus(1'b1, 8'hA5);
        runFrame("a5", 8'hA5, -1, 8'h00);
        @(negedge clk);
        checkCycle("a5 end", 8'h00, -1);

        applyStimulus(1'b1, 8'h01);
        runFrame("01", 8'h01, -1, 8'h00);
        @(negedge clk);
        checkCycle("01 end", 8'h00, -1);

        applyStimulus(1'b1, 8'h07);
        runFrame("07", 8'h07, -1, 8'h00);
        @(negedge clk);
        checkCycle("07 end", 8'h00, -1);

        applyStimulus(1'b1, 8'hA5);
        runFrame("b2b1", 8'hA5, FLEN - 1, 8'h3C);
        runFrame("b2b2", 8'h3C, -1, 8'h00);
        @(negedge clk);
        checkCycle("b2b end", 8'h00, -1);

        applyStimulus(1'b1, 8'hFF);
        runFrame("bp ff", 8'hFF, 2, 8'h00);
        runFrame("bp 00", 8'h00, -1, 8'h00);
        @(negedge clk);
        checkCycle("bp end", 8'h00, -1);

        applyStimulus(1'b1, 8'hA5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkCycle($sformatf("abort bit%0d", i), 8'hA5, i);
            if (i == 0) applyStimulus(1'b0, 8'h00);
        end
        reset = 1'b1;
        #1;
        checkCycle("abort async", 8'h00, -1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkCycle("abort idle", 8'h00, -1);
        applyStimulus(1'b1, 8'h3C);
        runFrame("post 3c", 8'h3C, -1, 8'h00);
        @(negedge clk);
        checkCycle("post end", 8'h00, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
